// File: rtl/fp24_pkg.sv
// fp24 format definitions shared by the multiplier and its issue front-end.
package fp24_pkg;

  localparam int unsigned FP24_W         = 24;
  localparam int unsigned FP24_EXP_W     = 7;
  localparam int unsigned FP24_MAN_W     = 16;
  localparam int unsigned FP24_BIAS      = 63;
  localparam int unsigned FP_MUL_LATENCY = 2;

  localparam logic [FP24_EXP_W-1:0] FP24_EXP_MAX = '1;

  typedef struct packed {
    logic                  sign;
    logic [FP24_EXP_W-1:0] expo;
    logic [FP24_MAN_W-1:0] man;
  } fp24_t;

endpackage

// File: rtl/fp_mul.sv
// fp24 multiplier: two register stages (operands, then product).
// Zero/denormal inputs and underflow flush to signed zero; overflow and
// infinite inputs give signed infinity; inf*0 gives a quiet NaN.
// Mantissa is truncated, no rounding.
module fp_mul
  import fp24_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  fp24_t a_i,
  input  fp24_t b_i,
  output fp24_t p_o
);

  localparam int unsigned SIG_W  = FP24_MAN_W + 1;
  localparam int unsigned PROD_W = 2 * SIG_W;
  localparam int unsigned ESUM_W = FP24_EXP_W + 2;

  fp24_t a_q, b_q, p_q, p_d;

  logic [PROD_W-1:0]     prod;
  logic                  norm;
  logic [FP24_MAN_W-1:0] man;
  logic [ESUM_W-1:0]     esum;
  logic                  sign, a_zero, b_zero, a_inf, b_inf;

  // Product datapath: significand multiply, normalise, exponent range checks.
  always_comb begin
    prod   = PROD_W'({1'b1, a_q.man}) * PROD_W'({1'b1, b_q.man});
    norm   = prod[PROD_W-1];
    man    = norm ? prod[PROD_W-2 -: FP24_MAN_W] : prod[PROD_W-3 -: FP24_MAN_W];
    esum   = ESUM_W'(a_q.expo) + ESUM_W'(b_q.expo) + ESUM_W'(norm);
    sign   = a_q.sign ^ b_q.sign;
    a_zero = (a_q.expo == '0);
    b_zero = (b_q.expo == '0);
    a_inf  = (a_q.expo == FP24_EXP_MAX);
    b_inf  = (b_q.expo == FP24_EXP_MAX);
    p_d    = '{sign: sign, expo: '0, man: '0};
    if ((a_zero && b_inf) || (a_inf && b_zero)) begin
      p_d = '{sign: 1'b0, expo: FP24_EXP_MAX, man: '1};
    end else if (a_inf || b_inf) begin
      p_d = '{sign: sign, expo: FP24_EXP_MAX, man: '0};
    end else if (a_zero || b_zero) begin
      p_d = '{sign: sign, expo: '0, man: '0};
    end else if (esum <= ESUM_W'(FP24_BIAS)) begin
      p_d = '{sign: sign, expo: '0, man: '0};
    end else if (esum >= ESUM_W'(FP24_BIAS) + ESUM_W'(FP24_EXP_MAX)) begin
      p_d = '{sign: sign, expo: FP24_EXP_MAX, man: '0};
    end else begin
      p_d = '{sign: sign, expo: FP24_EXP_W'(esum - ESUM_W'(FP24_BIAS)), man: man};
    end
  end

  // Operand and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
    end else begin
      a_q <= a_i;
      b_q <= b_i;
      p_q <= p_d;
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/fp_mul_issue.sv
// Valid/ready front-end for the non-stallable fp_mul pipeline. Occupancy
// credits (in-flight + stored) guarantee every product has a FIFO slot.
// Optional per-op tag transport: define FP_MUL_ISSUE_TAG_EN.
module fp_mul_issue
  import fp24_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = FP_MUL_LATENCY,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TAG_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP24_W-1:0] in_a,
  input  logic [FP24_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP24_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                   fire_in, fire_out, wr_en;
  logic [MUL_LATENCY-1:0] vld_q, vld_d;
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d, occ_q, occ_d;
  fp24_t                  a_op, b_op, prod;
  fp24_t                  mem_q [DEPTH];

  assign a_op = in_a;
  assign b_op = in_b;

  fp_mul u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .a_i   (a_op),
    .b_i   (b_op),
    .p_o   (prod)
  );

  // Handshakes; in_ready depends only on registered credits (and reset).
  assign in_ready  = rst_n && (occ_q < CNT_W'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign fire_in   = in_valid && in_ready;
  assign fire_out  = out_valid && out_ready;
  assign wr_en     = vld_q[MUL_LATENCY-1];
  assign out_result = mem_q[rd_ptr_q];

  // Next-state for valid pipe, FIFO fill count and credit counter.
  always_comb begin
    vld_d = MUL_LATENCY'({vld_q, fire_in});
    cnt_d = cnt_q;
    occ_d = occ_q;
    if (wr_en && !fire_out) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!wr_en && fire_out) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (fire_in && !fire_out) begin
      occ_d = occ_q + CNT_W'(1);
    end else if (!fire_in && fire_out) begin
      occ_d = occ_q - CNT_W'(1);
    end
  end

  // Valid pipe, FIFO storage/pointers and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      occ_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      occ_q <= occ_d;
      if (wr_en) begin
        mem_q[wr_ptr_q] <= prod;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (fire_out) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

`ifdef FP_MUL_ISSUE_TAG_EN
  logic [TAG_W-1:0] tag_pipe_q [MUL_LATENCY];
  logic [TAG_W-1:0] tag_mem_q  [DEPTH];

  // Tag pipe mirrors the multiplier latency; tag stored beside its product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
        tag_pipe_q[i] <= '0;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tag_mem_q[i] <= '0;
      end
    end else begin
      tag_pipe_q[0] <= in_tag;
      for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
        tag_pipe_q[i] <= tag_pipe_q[i-1];
      end
      if (wr_en) begin
        tag_mem_q[wr_ptr_q] <= tag_pipe_q[MUL_LATENCY-1];
      end
    end
  end

  assign out_tag = tag_mem_q[rd_ptr_q];
`else
  logic unused_tag;
  assign unused_tag = ^in_tag;
  assign out_tag    = '0;
`endif

  // FIFO must never be written while full, and credits never go negative.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_en && !fire_out && (cnt_q == CNT_W'(DEPTH))));
  assert property (@(posedge clk) disable iff (!rst_n)
    !(fire_out && (occ_q == '0)));

endmodule

// File: tb/tb_fp_mul_issue.sv
// Directed bench for fp_mul_issue: latency, streaming, back-pressure,
// sign/zero arithmetic, async reset mid-flight and tag ordering.
module tb_fp_mul_issue;

  typedef struct {
    logic [23:0] res;
    logic [3:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [23:0] in_a, in_b, out_result;
  logic [3:0]  in_tag, out_tag;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pops   = 0;
  int   n_fires  = 0;
  int   cyc      = 0;
  exp_t cur;
  exp_t exp_q [$];
  int   pop_cyc [$];
  logic        hold_q = 1'b0;
  logic [23:0] held_res;

  fp_mul_issue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [23:0] a, input logic [23:0] b,
                          input logic [23:0] res, input logic [3:0] tag);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    cur.res  = res;
`ifdef FP_MUL_ISSUE_TAG_EN
    cur.tag  = tag;
`else
    cur.tag  = 4'h0;
`endif
  endtask

  // Scoreboard: in-order result/tag check, head stability under back-pressure.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_q = 1'b0;
    end else begin
      cyc++;
      if (hold_q) begin
        check("head_hold_valid", 32'(out_valid), 32'd1);
        check("head_hold_result", 32'(out_result), 32'(held_res));
      end
      hold_q   = out_valid && !out_ready;
      held_res = out_result;
      if (out_valid && out_ready) begin
        n_pops++;
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result", 32'(out_result), 32'(e.res));
          check("tag", 32'(out_tag), 32'(e.tag));
        end
      end
      if (in_valid && in_ready) begin
        n_fires++;
        exp_q.push_back(cur);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic        f;
    int          j;
    logic [23:0] va [3];
    logic [23:0] vb [3];
    logic [23:0] vr [3];
    logic [3:0]  tags [3];

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
    cur.res = '0; cur.tag = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", 32'(out_result), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b1;
    #1 check("release_in_ready", 32'(in_ready), 32'd1);

    // 1: single op, latency 2 edges, 1.5*2.0 = 3.0
    tick();
    out_ready = 1'b1;
    drive_op(24'h3F8000, 24'h400000, 24'h408000, 4'h1);
    tick();
    in_valid = 1'b0;
    @(negedge clk) check("lat_edge0", 32'(out_valid), 32'd0);
    @(negedge clk) check("lat_edge1", 32'(out_valid), 32'd0);
    @(negedge clk) check("lat_edge2", 32'(out_valid), 32'd1);
    check("single_result", 32'(out_result), 32'h408000);
    repeat (3) tick();

    // 2: 16 back-to-back ops, results on consecutive cycles
    n_pops = 0;
    pop_cyc.delete();
    for (int i = 0; i < 16; i++) begin
      drive_op({1'b0, 7'(56 + i), 16'h0000}, 24'h3F8000, {1'b0, 7'(56 + i), 16'h8000}, 4'(i));
      @(negedge clk) check("stream_in_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    repeat (6) tick();
    check("stream_pops", 32'(n_pops), 32'd16);
    check("stream_left", 32'(exp_q.size()), 32'd0);
    if (pop_cyc.size() == 16) begin
      check("stream_span", 32'(pop_cyc[15] - pop_cyc[0]), 32'd15);
    end else begin
      check("stream_pop_cycles", 32'(pop_cyc.size()), 32'd16);
    end

    // 3: back-pressure, exactly DEPTH accepted, then in-order drain
    out_ready = 1'b0;
    n_fires = 0;
    j = 0;
    drive_op({1'b0, 7'(60), 16'h0}, 24'h400000, {1'b0, 7'(61), 16'h0}, 4'h0);
    repeat (10) begin
      @(negedge clk) f = in_ready;
      tick();
      if (f) begin
        j++;
        drive_op({1'b0, 7'(60 + j), 16'h0}, 24'h400000, {1'b0, 7'(61 + j), 16'h0}, 4'(j));
      end
    end
    in_valid = 1'b0;
    check("bp_accepted", 32'(n_fires), 32'd4);
    @(negedge clk) check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    n_pops = 0;
    tick();
    out_ready = 1'b1;
    repeat (8) tick();
    check("bp_pops", 32'(n_pops), 32'd4);
    check("bp_left", 32'(exp_q.size()), 32'd0);
    check("bp_in_ready_back", 32'(in_ready), 32'd1);

    // 4: zero/sign and normalisation carry
    va[0] = 24'h000000; vb[0] = 24'hBF0000; vr[0] = 24'h800000;
    va[1] = 24'hBF8000; vb[1] = 24'h400000; vr[1] = 24'hC08000;
    va[2] = 24'h3F8000; vb[2] = 24'h3F8000; vr[2] = 24'h402000;
    n_pops = 0;
    for (int i = 0; i < 3; i++) begin
      drive_op(va[i], vb[i], vr[i], 4'(i));
      tick();
    end
    in_valid = 1'b0;
    repeat (5) tick();
    check("arith_pops", 32'(n_pops), 32'd3);
    check("arith_left", 32'(exp_q.size()), 32'd0);

    // 5: async reset with 1 op in FIFO and 2 in the pipe
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_op(24'h3F8000, 24'h400000, 24'h408000, 4'h7);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk) check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd0);
    check("async_rst_out_result", 32'(out_result), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("post_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    n_pops = 0;
    repeat (6) begin
      @(negedge clk) check("post_rst_no_stale", 32'(out_valid), 32'd0);
    end
    check("post_rst_pops", 32'(n_pops), 32'd0);

    // 6: tagged ops with random out_ready
    tick();
    va[0] = 24'h3F8000; vr[0] = 24'h408000; tags[0] = 4'h3;
    va[1] = 24'h3F4000; vr[1] = 24'h404000; tags[1] = 4'hA;
    va[2] = 24'h3FC000; vr[2] = 24'h40C000; tags[2] = 4'h5;
    n_pops = 0;
    j = 0;
    drive_op(24'h400000, va[0], vr[0], tags[0]);
    repeat (30) begin
      @(negedge clk) f = in_valid && in_ready;
      tick();
      out_ready = 1'($urandom_range(0, 1));
      if (f) begin
        j++;
        if (j < 3) drive_op(24'h400000, va[j], vr[j], tags[j]);
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    check("tag_pops", 32'(n_pops), 32'd3);
    check("tag_left", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
